// File: rtl/dump_input_file.sv
// Reads the 1-bit-per-pixel image memory back out and packs it LSB-first into bytes for the UART transmitter.
// Optional feature: define DUMP_CHECKSUM_EN to append an XOR checksum byte after the image bytes.
module dump_input_file #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    input  logic              q,
    output logic [7:0]        tx_data,
    output logic              tx_trigger,
    input  logic              tx_done,
    output logic              busy,
    output logic              done
);
    localparam int NUM_BYTES = NUM_BITS / 8;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [3:0]          bit_q, bit_d;
    logic [7:0]          sh_q, sh_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          sh_in;
    logic                last_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                csum_sent_q, csum_sent_d;
`endif

    // Memory read is registered, so q on f(k+1) belongs to the address shown on fk.
    assign sh_in     = {q, sh_q[7:1]};
    assign last_byte = (byte_q == BYTE_W'(NUM_BYTES - 1));

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        tx_data_d = tx_data_q;
        addr_d    = addr_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    byte_d  = '0;
                    bit_d   = '0;
                    sh_d    = '0;
                    addr_d  = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d      = '0;
                    csum_sent_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (bit_q != 4'd0) begin
                    sh_d = sh_in;
                end
                // Address stops at 8*byte+7; f8 only collects the final read.
                if (bit_q < 4'd7) begin
                    addr_d = addr_q + 1'b1;
                end
                if (bit_q == 4'd8) begin
                    state_d   = S_SEND;
                    bit_d     = '0;
                    tx_data_d = sh_in;
`ifdef DUMP_CHECKSUM_EN
                    csum_d    = csum_q ^ sh_in;
`endif
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (!last_byte) begin
                        state_d = S_FETCH;
                        byte_d  = byte_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        if (!csum_sent_q) begin
                            // Checksum byte skips FETCH; addr stays on the last image bit.
                            state_d     = S_SEND;
                            csum_sent_d = 1'b1;
                            tx_data_d   = csum_q;
                        end else begin
                            state_d = S_FIN;
                            addr_d  = '0;
                        end
`else
                        state_d = S_FIN;
                        addr_d  = '0;
`endif
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            byte_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            tx_data_q <= '0;
            addr_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            tx_data_q <= tx_data_d;
            addr_q    <= addr_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign tx_data    = tx_data_q;
    assign tx_trigger = (state_q == S_SEND);
    assign busy       = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_WAIT);
    assign done       = (state_q == S_FIN);

endmodule
